// File: rtl/act_rd_sched_if.sv
// rtl/act_rd_sched_if.sv - consumer/FIFO signal bundle for the activation FIFO read scheduler
interface act_rd_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int BURST_W = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [BURST_W-1:0] cfg_burst;
  logic [NUM_REQ-1:0] req_rdy;
  logic [NUM_REQ-1:0] req_val;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;

  modport master (
    input  cfg_burst,
    input  req_rdy,
    input  fifo_empty,
    input  fifo_push,
    output req_val,
    output fifo_pop,
    output gnt_id,
    output busy
  );

  modport slave (
    output cfg_burst,
    output req_rdy,
    output fifo_empty,
    output fifo_push,
    input  req_val,
    input  fifo_pop,
    input  gnt_id,
    input  busy
  );
endinterface

// File: rtl/act_rd_sched.sv
// rtl/act_rd_sched.sv - round-robin burst read scheduler for the shared FWFT activation FIFO
module act_rd_sched #(
  parameter int NUM_REQ = 2,
  parameter int BURST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset,
  act_rd_sched_if.master    bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [ID_W-1:0]    last_gnt_q;
  logic [BURST_W-1:0] cnt_q;
  logic               busy_q;

  logic               pop;
  logic [NUM_REQ-1:0] req_val_d;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    cand;
  logic [BURST_W-1:0] burst_ld;

  // Walk offsets from far to near so the nearest ready consumer after last_gnt wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_gnt_q) + k) % NUM_REQ);
      if (bus.req_rdy[cand]) begin
        sel_valid = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign burst_ld = (bus.cfg_burst == '0) ? BURST_W'(1) : bus.cfg_burst;

  // The writer always wins; a sync reset cycle must also not pop.
  always_comb begin
    pop       = 1'b0;
    req_val_d = '0;
    if (state_q == GRANT && !reset) begin
      pop = bus.req_rdy[gnt_id_q] & ~bus.fifo_empty & ~bus.fifo_push;
    end
    req_val_d[gnt_id_q] = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_id_q   <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      busy_q     <= 1'b0;
    end else if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_id_q   <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.fifo_empty && sel_valid) begin
            gnt_id_q <= sel_id;
            cnt_q    <= burst_ld;
            state_q  <= GRANT;
            busy_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (!bus.req_rdy[gnt_id_q]) begin
            // Consumer backed off: give up the rest of the burst.
            last_gnt_q <= gnt_id_q;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end else if (pop && cnt_q != '0) begin
            cnt_q <= cnt_q - BURST_W'(1);
            if (cnt_q == BURST_W'(1)) begin
              last_gnt_q <= gnt_id_q;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.req_val  = req_val_d;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_act_rd_sched.sv
// tb/tb_act_rd_sched.sv - directed bench for act_rd_sched with a word-count FIFO model
module tb_act_rd_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic reset;
  logic load_en;
  int   load_val;
  int   fcnt = 0;
  int   p0 = 0;
  int   p1 = 0;
  int   base;
  int   n_pass = 0;
  int   n_chk = 0;

  logic [1:0] rr_exp [0:11] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
  logic       rr_gnt [0:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       wp_pop [0:8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  act_rd_sched_if #(.NUM_REQ(2), .BURST_W(4)) bus ();

  act_rd_sched #(.NUM_REQ(2), .BURST_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (load_en) fcnt <= load_val;
    else         fcnt <= fcnt + int'(bus.fifo_push) - int'(bus.fifo_pop);
    if (bus.req_val[0]) p0 <= p0 + 1;
    if (bus.req_val[1]) p1 <= p1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; reset = 1'b0; load_en = 1'b0; load_val = 0;
    bus.req_rdy = 2'b00; bus.fifo_push = 1'b0; bus.cfg_burst = 4'd4;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pop", 32'(bus.fifo_pop), 32'd0);
    check("rst_req_val", 32'(bus.req_val), 32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // single consumer, burst 4, 8 words
    load_en = 1'b1; load_val = 8;
    step();
    load_en = 1'b0;
    bus.req_rdy = 2'b01;
    #1;
    check("s1_c0_pop", 32'(bus.fifo_pop), 32'd0);
    for (int c = 1; c <= 9; c++) begin
      step(); #1;
      check($sformatf("s1_c%0d_pop", c), 32'(bus.fifo_pop), (c == 5) ? 32'd0 : 32'd1);
      check($sformatf("s1_c%0d_req_val", c), 32'(bus.req_val), (c == 5) ? 32'd0 : 32'd1);
      check($sformatf("s1_c%0d_gnt", c), 32'(bus.gnt_id), 32'd0);
    end
    step(); #1;
    check("s1_end_busy", 32'(bus.busy), 32'd0);
    check("s1_pops0", 32'(p0), 32'd8);
    check("s1_pops1", 32'(p1), 32'd0);

    // round robin, burst 2
    bus.req_rdy = 2'b00; reset = 1'b1; bus.cfg_burst = 4'd2;
    load_en = 1'b1; load_val = 8;
    step();
    reset = 1'b0; load_en = 1'b0;
    bus.req_rdy = 2'b11;
    #1;
    check("rr_c0_pop", 32'(bus.fifo_pop), 32'd0);
    for (int c = 1; c <= 11; c++) begin
      step(); #1;
      check($sformatf("rr_c%0d_req_val", c), 32'(bus.req_val), 32'(rr_exp[c]));
      check($sformatf("rr_c%0d_gnt", c), 32'(bus.gnt_id), 32'(rr_gnt[c]));
    end
    bus.req_rdy = 2'b00;

    // writer priority inside a burst of 4
    reset = 1'b1; bus.cfg_burst = 4'd4; load_en = 1'b1; load_val = 8;
    step();
    reset = 1'b0; load_en = 1'b0;
    base = p0;
    bus.req_rdy = 2'b01;
    #1;
    check("wp_c0_pop", 32'(bus.fifo_pop), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.fifo_push = (c >= 3 && c <= 5);
      if (c == 8) bus.req_rdy = 2'b00;
      #1;
      check($sformatf("wp_c%0d_pop", c), 32'(bus.fifo_pop), 32'(wp_pop[c]));
      check($sformatf("wp_c%0d_busy", c), 32'(bus.busy), (c == 8) ? 32'd0 : 32'd1);
    end
    bus.fifo_push = 1'b0;
    step(); #1;
    check("wp_pops0", 32'(p0 - base), 32'd4);

    // early release by consumer 0
    reset = 1'b1; load_en = 1'b1; load_val = 8;
    step();
    reset = 1'b0; load_en = 1'b0;
    base = p0;
    bus.req_rdy = 2'b11;
    #1;
    step(); #1;
    check("er_c1_req_val", 32'(bus.req_val), 32'd1);
    step(); #1;
    check("er_c2_req_val", 32'(bus.req_val), 32'd1);
    step();
    bus.req_rdy = 2'b10;
    #1;
    check("er_c3_pop", 32'(bus.fifo_pop), 32'd0);
    check("er_c3_busy", 32'(bus.busy), 32'd1);
    step(); #1;
    check("er_c4_busy", 32'(bus.busy), 32'd0);
    check("er_c4_pop", 32'(bus.fifo_pop), 32'd0);
    step(); #1;
    check("er_c5_req_val", 32'(bus.req_val), 32'd2);
    check("er_c5_gnt", 32'(bus.gnt_id), 32'd1);
    bus.req_rdy = 2'b00;
    step(); #1;
    check("er_pops0", 32'(p0 - base), 32'd2);

    // zero burst config and empty stall
    reset = 1'b1; bus.cfg_burst = 4'd0; load_en = 1'b1; load_val = 1;
    step();
    reset = 1'b0; load_en = 1'b0;
    bus.req_rdy = 2'b11;
    #1;
    check("ze_c0_pop", 32'(bus.fifo_pop), 32'd0);
    step(); #1;
    check("ze_c1_req_val", 32'(bus.req_val), 32'd1);
    step(); #1;
    check("ze_c2_busy", 32'(bus.busy), 32'd0);
    check("ze_c2_pop", 32'(bus.fifo_pop), 32'd0);
    step();
    bus.fifo_push = 1'b1;
    #1;
    check("ze_c3_busy", 32'(bus.busy), 32'd0);
    step();
    bus.fifo_push = 1'b0;
    #1;
    check("ze_c4_busy", 32'(bus.busy), 32'd0);
    step(); #1;
    check("ze_c5_busy", 32'(bus.busy), 32'd1);
    check("ze_c5_gnt", 32'(bus.gnt_id), 32'd1);
    check("ze_c5_req_val", 32'(bus.req_val), 32'd2);

    // asynchronous reset during a grant
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_pop", 32'(bus.fifo_pop), 32'd0);
    check("ar_req_val", 32'(bus.req_val), 32'd0);
    check("ar_gnt", 32'(bus.gnt_id), 32'd0);
    step();
    rst_n = 1'b1; bus.cfg_burst = 4'd4; bus.req_rdy = 2'b00;
    load_en = 1'b1; load_val = 8;
    step();
    load_en = 1'b0;
    bus.req_rdy = 2'b11;
    #1;
    check("ar_c0_pop", 32'(bus.fifo_pop), 32'd0);
    step(); #1;
    check("ar_c1_req_val", 32'(bus.req_val), 32'd1);
    check("ar_c1_gnt", 32'(bus.gnt_id), 32'd0);

    // synchronous reset during the same grant
    step();
    reset = 1'b1;
    #1;
    check("sr_cycle_pop", 32'(bus.fifo_pop), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("sr_busy", 32'(bus.busy), 32'd0);
    check("sr_pop", 32'(bus.fifo_pop), 32'd0);
    check("sr_req_val", 32'(bus.req_val), 32'd0);
    check("sr_gnt", 32'(bus.gnt_id), 32'd0);
    step(); #1;
    check("sr_next_req_val", 32'(bus.req_val), 32'd1);
    check("sr_next_gnt", 32'(bus.gnt_id), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/act_rd_sched.md
# act_rd_sched

Read-side scheduler for the shared activation FIFO: grants one of `NUM_REQ` consumers (REGACT, PEB, …) exclusive pop access to a single first-word-fall-through FIFO for a configurable burst of words, rotating grants round-robin. The writer keeps absolute priority, so no pop is issued in a cycle where the FIFO is pushed. It sits between the activation FIFO and its consumers in the PEB and replaces fixed-priority pop gating.

## Interface
- `NUM_REQ`, 2: number of consumers (2..8).
- `BURST_W`, 4: width of the burst-length configuration and counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `reset`  in  1  synchronous clear: same effect as `rst_n`, applied at the clock edge.
- `cfg_burst`  in  `BURST_W`  words per grant; 0 is treated as 1; sampled at grant time.
- `req_rdy`  in  `NUM_REQ`  consumer i can accept a word this cycle.
- `req_val`  out  `NUM_REQ`  word on the FIFO output is delivered to consumer i this cycle; one-hot or zero.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_push`  in  1  writer pushes this cycle; highest priority.
- `fifo_pop`  out  1  pop strobe to the FIFO; equals `|req_val`.
- `gnt_id`  out  `$clog2(NUM_REQ)`  current or last granted consumer.
- `busy`  out  1  state is GRANT.

## Operation
- FSM has two states, IDLE and GRANT.
- Registers: `state`, `gnt_id`, `last_gnt`, `cnt` [`BURST_W`].
- IDLE:
  - If `!fifo_empty` and `|req_rdy`, choose the first i with `req_rdy[i]=1`, searching upward from `last_gnt+1` modulo `NUM_REQ`.
  - Register it into `gnt_id`, load `cnt` with `max(cfg_burst,1)`, and go to GRANT.
  - Otherwise stay in IDLE.
  - No pop is ever issued in IDLE.
- GRANT:
  - Combinational: `pop = req_rdy[gnt_id] & !fifo_empty & !fifo_push`; `req_val[gnt_id] = pop`; all other `req_val` bits are 0.
  - On `pop`, `cnt` decrements. If `cnt==1` on that pop, the burst is complete: set `last_gnt <= gnt_id` and go to IDLE.
  - If `req_rdy[gnt_id]==0`, the grant is released early: set `last_gnt <= gnt_id`, go to IDLE, no pop. The partial burst is abandoned.
  - `fifo_empty` or `fifo_push` stalls the burst and holds the grant. Stalls have no timeout.
- `req_rdy` of non-granted consumers is ignored during GRANT.
- Counter width rule: `cnt` never wraps. The decrement happens only when `cnt>=1`, and loading 0 is impossible.
- Reset (async `rst_n` low, or sync `reset` high):
  - `state` = IDLE, `cnt` = 0, `gnt_id` = 0, `last_gnt` = `NUM_REQ-1`, so the first grant goes to consumer 0.
  - All outputs 0.
  - A reset in mid-burst abandons the burst with no pop in the reset cycle.

## Timing
- Arbitration latency is 1 cycle. The request is seen in IDLE at cycle t, `busy` rises at t+1, and the first pop can occur at t+1.
- Sustained throughput inside a burst is 1 word/cycle when the FIFO is non-empty and there is no push.
- Burst overhead is 1 idle cycle between consecutive grants.
- `fifo_pop` and `req_val` are combinational from `req_rdy`, `fifo_empty`, `fifo_push` and registered state. There is no registered-output latency.
- Data is taken directly from the FWFT FIFO output by the consumer whose `req_val` is high.
- Simultaneous push and pop request: the push wins, no pop is issued, and `cnt` is unchanged.
- Last word leaving the FIFO (`fifo_empty` rises after a pop): the grant is held in GRANT and the burst resumes when data returns.

## Test plan
- Single consumer, full rate: `NUM_REQ=2`, `cfg_burst=4`, FIFO holds 8, `req_rdy=2'b01` constant.
  - Pops at cycles 1–4, idle at cycle 5, pops at cycles 6–9.
  - `req_val[1]` is never high; `gnt_id` stays 0.
- Round-robin fairness: `cfg_burst=2`, `req_rdy=2'b11`, FIFO holds 8.
  - Grant order 0,1,0,1 with exactly 2 pops each; `req_val` is never `2'b11`.
- Writer priority: mid-burst, assert `fifo_push` for 3 cycles with `req_rdy` held.
  - `fifo_pop=0` in those 3 cycles, `cnt` frozen, and the burst completes with the full 4 pops afterwards.
- Early release: `cfg_burst=4`, consumer 0 drops `req_rdy` after 2 pops while consumer 1 is ready.
  - Next grant goes to consumer 1 after 1 IDLE cycle, and the total number of pops to consumer 0 is 2.
- Empty stall and zero config: `cfg_burst=0`, FIFO holds 1 word.
  - One pop, then IDLE; with the FIFO empty there is no grant even if `req_rdy=2'b11`.
  - Push 1 word: a grant issues to the next consumer in rotation.
- Reset mid-operation: assert `rst_n=0` asynchronously during GRANT, then separately pulse `reset` for 1 cycle during GRANT.
  - Each time, `busy`, `fifo_pop`, `req_val` and `gnt_id` go to 0 (immediately for `rst_n`, at the edge for `reset`).
  - The first grant after reset goes to consumer 0.
